// File: rtl/usb_mem_responder_pkg.sv
// usb_mem_responder_pkg
// Shared definitions for the USB memory responder slice:
//   - address-map constants for the 26-bit USB byte-address window
//   - data width of a transfer word
//   - responder FSM state encoding
package usb_mem_responder_pkg;

  // USB-side window is 64 MiB of byte addresses, accessed as 32-bit words.
  localparam int USB_ADDR_W     = 26;
  localparam int USB_BYTE_OFS_W = 2;   // byte offset bits inside a 32-bit word
  localparam int USB_DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_WAIT
  } resp_state_t;

endpackage

// File: rtl/usb_wr_fifo.sv
// usb_wr_fifo
// Synchronous FIFO holding posted USB writes until memory accepts them.
// The head entry is presented combinationally so it can drive the memory
// request fields directly while the request is held.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push          write push_data (accepted when not full, or when a pop
//                 happens in the same cycle)
//   push_data     entry to store
//   pop           drop the head entry (ignored when empty)
//   head_data     oldest entry
//   count         number of stored entries
//   full, empty   status flags
module usb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 56
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push alongside it still fits.
  assign push_ok = push && (!full || pop_ok);

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/usb_mem_responder.sv
// usb_mem_responder
// Bridges a USB transfer engine to a single-outstanding memory port.
// Writes are posted into a small FIFO and drained to memory in order; when
// no writes are pending, the word at the current USB address is prefetched
// so it is ready before the USB side asks for it.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   usb_addr                        current 4-aligned byte address
//   usb_wr, usb_wr_data, usb_wr_ready   posted-write interface
//   usb_rd, usb_rd_ready, usb_rd_valid, usb_rd_data   prefetched-read interface
//   mem_req, mem_we, mem_addr, mem_wdata, mem_gnt     memory request (held until gnt)
//   mem_rvalid, mem_rdata           memory read return
module usb_mem_responder
  import usb_mem_responder_pkg::*;
#(
  parameter int WFIFO_DEPTH = 4,
  parameter int ADDR_W      = USB_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       usb_addr,
  input  logic                    usb_wr,
  input  logic [USB_DATA_W-1:0]   usb_wr_data,
  output logic                    usb_wr_ready,
  input  logic                    usb_rd,
  output logic                    usb_rd_ready,
  output logic                    usb_rd_valid,
  output logic [USB_DATA_W-1:0]   usb_rd_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-3:0]       mem_addr,
  output logic [USB_DATA_W-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [USB_DATA_W-1:0]   mem_rdata
);

  localparam int WORD_W  = ADDR_W - USB_BYTE_OFS_W;
  localparam int ENTRY_W = WORD_W + USB_DATA_W;
  localparam int CNT_W   = $clog2(WFIFO_DEPTH) + 1;

  resp_state_t           state_reg, state_next;
  logic [ADDR_W-1:0]     rd_addr_reg;
  logic                  rd_valid_reg, rd_valid_next;
  logic [USB_DATA_W-1:0] rd_data_reg;
  logic                  capture_rd;
  logic                  load_rd;
  logic                  addr_match;

  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WORD_W-1:0]     head_word;
  logic [USB_DATA_W-1:0] head_wdata;

  // Only the word address is stored; usb_addr is always 4-aligned.
  usb_wr_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (usb_wr),
    .push_data ({usb_addr[ADDR_W-1:USB_BYTE_OFS_W], usb_wr_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_word, head_wdata} = fifo_head;
  assign addr_match   = (usb_addr == rd_addr_reg);
  assign usb_wr_ready = !fifo_full;
  assign usb_rd_ready = (fifo_count == '0) && (state_reg != ST_WR_REQ);
  assign usb_rd_valid = rd_valid_reg;
  assign usb_rd_data  = rd_data_reg;

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fifo_pop   = 1'b0;
    capture_rd = 1'b0;
    load_rd    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A write arriving this cycle lands in the FIFO next cycle; holding
        // off the read keeps it from overtaking that write.
        if (!fifo_empty) begin
          state_next = ST_WR_REQ;
        end else if (!usb_wr && !rd_valid_reg) begin
          state_next = ST_RD_REQ;
          capture_rd = 1'b1;
        end
      end
      ST_WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_word;
        mem_wdata = head_wdata;
        if (mem_gnt) begin
          fifo_pop   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr_reg[ADDR_W-1:USB_BYTE_OFS_W];
        if (mem_gnt) state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          // Returned data is only trustworthy if nothing could have changed
          // the word meanwhile and the USB side still wants that address.
          load_rd    = fifo_empty && !usb_wr && addr_match;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (load_rd) begin
      rd_valid_next = 1'b1;
    end else if (usb_rd || usb_wr || !addr_match) begin
      rd_valid_next = 1'b0;
    end else begin
      rd_valid_next = rd_valid_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rd_addr_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= rd_valid_next;
      if (capture_rd) rd_addr_reg <= usb_addr;
      if (load_rd)    rd_data_reg <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_usb_mem_responder.sv
// tb_usb_mem_responder
// Directed bench for usb_mem_responder: a memory responder with adjustable
// grant/latency, a scoreboard model of the posted-write queue and the
// prefetch buffer checked every cycle, and literal checks per scenario.
module tb_usb_mem_responder;

  localparam int DEPTH = 4;
  localparam int AW    = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] usb_addr;
  logic          usb_wr;
  logic [31:0]   usb_wr_data;
  logic          usb_wr_ready;
  logic          usb_rd;
  logic          usb_rd_ready;
  logic          usb_rd_valid;
  logic [31:0]   usb_rd_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  usb_mem_responder #(.WFIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .usb_addr(usb_addr), .usb_wr(usb_wr),
    .usb_wr_data(usb_wr_data), .usb_wr_ready(usb_wr_ready), .usb_rd(usb_rd),
    .usb_rd_ready(usb_rd_ready), .usb_rd_valid(usb_rd_valid),
    .usb_rd_data(usb_rd_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic        gnt_en = 1'b1;
  int          rd_lat = 1;
  logic        force_en = 1'b0;
  logic [31:0] force_data = 32'h0;
  logic [31:0] mem_model [int];
  logic        rd_pending = 1'b0;
  int          rd_cd = 0;
  int          rd_word = 0;

  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt) begin
      if (mem_we) begin
        mem_model[int'(mem_addr)] = mem_wdata;
      end else begin
        rd_pending = 1'b1;
        rd_cd      = rd_lat;
        rd_word    = int'(mem_addr);
      end
    end
  end

  // A pending read is deliberately not cancelled by rst, so a reset can
  // leave a stray return behind.
  always @(posedge clk) begin
    #2;
    mem_rvalid = 1'b0;
    if (rd_pending) begin
      if (rd_cd <= 1) begin
        mem_rvalid = 1'b1;
        if (force_en) mem_rdata = force_data;
        else if (mem_model.exists(rd_word)) mem_rdata = mem_model[rd_word];
        else mem_rdata = 32'h0;
        rd_pending = 1'b0;
      end else begin
        rd_cd--;
      end
    end
    mem_gnt = gnt_en && mem_req;
  end

  // ---------------- scoreboard model ----------------
  int              m_cnt = 0;
  logic            m_valid = 1'b0;
  logic [31:0]     m_data = 32'h0;
  logic [AW-1:0]   m_vaddr = '0;
  logic            m_out = 1'b0;
  logic [AW-3:0]   m_out_word = '0;
  logic [AW+29:0]  exp_q [$];
  logic            prev_rd_req = 1'b0;
  logic [AW-3:0]   rd_req_word = '0;
  int              n_wr_done = 0;
  logic            m_pop, m_push, m_load;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_ready", usb_wr_ready, 1'b1);
      chk("rst_rd_ready", usb_rd_ready, 1'b1);
      chk("rst_rd_valid", usb_rd_valid, 1'b0);
      chk("rst_rd_data", usb_rd_data, 32'h0);
      chk("rst_mem_fields", {mem_req, mem_we, mem_addr, mem_wdata}, 64'h0);
      m_cnt = 0; m_valid = 1'b0; m_data = 32'h0; m_out = 1'b0;
      prev_rd_req = 1'b0;
      exp_q.delete();
    end else begin
      chk("wr_ready", usb_wr_ready, m_cnt < DEPTH);
      chk("rd_ready", usb_rd_ready, m_cnt == 0);
      chk("rd_valid", usb_rd_valid, m_valid);
      chk("rd_data", usb_rd_data, m_data);

      m_pop = mem_req && mem_we && mem_gnt;
      if (mem_req && mem_we) begin
        chk("wr_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) chk("wr_entry", {mem_addr, mem_wdata}, exp_q[0]);
      end
      if (m_pop && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_wr_done++;
      end

      // Return handling precedes grant handling: a return can never belong
      // to a read granted in the same cycle.
      m_load = 1'b0;
      if (mem_rvalid && m_out) begin
        m_out  = 1'b0;
        m_load = (m_cnt == 0) && !usb_wr && (usb_addr == {m_out_word, 2'b00});
      end

      if (mem_req && !mem_we) begin
        if (!prev_rd_req) begin
          chk("rd_after_writes", m_cnt, 0);
          rd_req_word = mem_addr;
        end else begin
          chk("rd_addr_held", mem_addr, rd_req_word);
        end
        prev_rd_req = !mem_gnt;
        if (mem_gnt) begin
          m_out      = 1'b1;
          m_out_word = mem_addr;
        end
      end else begin
        prev_rd_req = 1'b0;
      end

      if (m_load) begin
        m_valid = 1'b1;
        m_data  = mem_rdata;
        m_vaddr = usb_addr;
      end else if (m_valid && (usb_rd || usb_wr || usb_addr != m_vaddr)) begin
        m_valid = 1'b0;
      end

      m_push = usb_wr && (m_cnt < DEPTH || m_pop);
      if (m_push) exp_q.push_back({usb_addr[AW-1:2], usb_wr_data});
      m_cnt = m_cnt + int'(m_push) - int'(m_pop && m_cnt > 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    int t = 0;
    while (!usb_wr_ready && t < 60) begin
      tick();
      t++;
    end
    chk("wr_ready_before_push", usb_wr_ready, 1'b1);
    usb_addr    = a;
    usb_wr_data = d;
    usb_wr      = 1'b1;
    tick();
    usb_wr      = 1'b0;
  endtask

  task automatic wait_rd_req(input logic [AW-3:0] w, input string name);
    int t = 0;
    @(negedge clk);
    while (!(mem_req && !mem_we) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, w});
  endtask

  task automatic wait_rvalid(input string name);
    int t = 0;
    @(negedge clk);
    while (!mem_rvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, mem_rvalid, 1'b1);
  endtask

  task automatic wait_valid(input logic [31:0] d, input string name);
    int t = 0;
    @(negedge clk);
    while (!usb_rd_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, {usb_rd_valid, usb_rd_data}, {1'b1, d});
  endtask

  task automatic wait_writes(input int target, input int base, input string name);
    int t = 0;
    while (n_wr_done - base < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, n_wr_done - base, target);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    int n_low;
    int wr_cyc;
    int rd_cyc;
    rst = 1'b1; usb_addr = 26'h2000000; usb_wr = 1'b0; usb_wr_data = 32'h0;
    usb_rd = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    gnt_en = 1'b1; rd_lat = 3; force_en = 1'b1; force_data = 32'hDEADBEEF;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", {usb_wr_ready, usb_rd_valid, mem_req}, 3'b100);

    // Prefetch at 0x02000000 with 3-cycle return latency.
    tick(); rst = 1'b0;
    @(negedge clk); chk("idle_no_req", mem_req, 1'b0);
    @(negedge clk); chk("prefetch_req_next_cycle", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 24'h800000});
    wait_rvalid("prefetch_rvalid");
    @(negedge clk); chk("prefetch_valid_latency", {usb_rd_valid, usb_rd_data}, {1'b1, 32'hDEADBEEF});
    tick(); usb_rd = 1'b1; usb_addr = 26'h2000004; force_data = 32'hCAFEF00D;
    tick(); usb_rd = 1'b0;
    wait_rd_req(24'h800001, "next_read_word");
    wait_valid(32'hCAFEF00D, "next_read_data");

    // Burst of 6 writes with the grant withheld for 10 cycles.
    tick(); force_en = 1'b0; rd_lat = 1; gnt_en = 1'b0; base = n_wr_done;
    for (int i = 0; i < 4; i++) do_write(AW'(i * 4), 32'hA0 + 32'(i));
    chk("burst_full_after4", usb_wr_ready, 1'b0);
    n_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!usb_wr_ready) n_low++;
    end
    chk("burst_hold_low", n_low, 10);
    gnt_en = 1'b1;
    for (int i = 4; i < 6; i++) do_write(AW'(i * 4), 32'hA0 + 32'(i));
    wait_writes(6, base, "burst_all_written");
    chk("burst_mem_first", mem_model[0], 32'hA0);
    chk("burst_mem_last", mem_model[5], 32'hA5);
    wait_valid(32'hA5, "burst_readback");

    // Full FIFO: push in the same cycle as a pop.
    tick(); gnt_en = 1'b0; base = n_wr_done;
    for (int i = 0; i < 4; i++) do_write(AW'(32'h200 + i * 4), 32'h1000 + 32'(i));
    chk("full_wr_req_held", {usb_wr_ready, mem_req, mem_we}, 3'b011);
    gnt_en = 1'b1; usb_addr = 26'h210; usb_wr_data = 32'h1004; usb_wr = 1'b1;
    tick(); usb_wr = 1'b0;
    chk("full_push_pop_ready", usb_wr_ready, 1'b0);
    wait_writes(5, base, "full_none_lost");
    chk("full_last_mem", mem_model[32'h84], 32'h1004);
    wait_valid(32'h1004, "full_readback");

    // Ordering: write then read of the same address.
    tick(); do_write(26'h100, 32'h11223344);
    wr_cyc = -1; rd_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req && mem_we && mem_gnt && mem_addr == 24'h40 && wr_cyc < 0) wr_cyc = i;
      if (mem_req && !mem_we && mem_addr == 24'h40 && rd_cyc < 0) rd_cyc = i;
    end
    chk("order_write_first", (wr_cyc >= 0) && (rd_cyc > wr_cyc), 1'b1);
    wait_valid(32'h11223344, "order_readback");

    // Stale: address moves while the read is outstanding.
    tick(); force_en = 1'b1; force_data = 32'h55AA0020; rd_lat = 4; usb_addr = 26'h20;
    wait_rd_req(24'h8, "stale_first_req");
    tick(); usb_addr = 26'h24;
    wait_rvalid("stale_rvalid");
    force_data = 32'h55AA0024;
    @(negedge clk); chk("stale_dropped", usb_rd_valid, 1'b0);
    wait_rd_req(24'h9, "stale_new_req");
    wait_valid(32'h55AA0024, "stale_new_data");

    // Reset during RD_WAIT; the late return must be ignored.
    tick(); force_data = 32'h0BADF00D; rd_lat = 5; usb_addr = 26'h40;
    wait_rd_req(24'h10, "rst_first_req");
    tick(); tick();
    rst = 1'b1; gnt_en = 1'b0;
    tick(); rst = 1'b0;
    wait_rvalid("late_rvalid");
    @(negedge clk);
    chk("late_rvalid_ignored", {usb_rd_valid, mem_req, mem_we, mem_addr}, {1'b0, 1'b1, 1'b0, 24'h10});
    gnt_en = 1'b1; force_data = 32'h600DF00D;
    wait_valid(32'h600DF00D, "rst_reissue_data");

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
